// File: rtl/snd_pkg.sv
// Shared types and constants for the sound event sequencer.
// Note half-periods assume a 50 MHz clk.
package snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned NOTE_A = 56818;  // 440 Hz
  localparam int unsigned NOTE_G = 63776;  // 392 Hz
  localparam int unsigned NOTE_C = 47778;  // 523.25 Hz

  localparam logic GAIN_6DB = 1'b1;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: a phase counter that wraps at period-1 and toggles audio.
// load captures a new period and restarts at phase 0 with audio low; clear silences.
module tone_gen #(
  parameter int PERIOD_W = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                audio
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      phase    <= '0;
      audio    <= 1'b0;
    end else if (load) begin
      period_q <= period;
      phase    <= '0;
      audio    <= 1'b0;
    end else if (clear) begin
      phase <= '0;
      audio <= 1'b0;
    end else if (phase == period_q - 1'b1) begin
      phase <= '0;
      audio <= ~audio;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/sound_event_sequencer.sv
// Fixed-priority sound event sequencer: latches requests, plays one event at a time
// with optional preemption and sustained events, and inserts a silent gap between events.
module sound_event_sequencer
  import snd_pkg::*;
#(
  parameter int                NUM_EV       = 4,
  parameter int                PERIOD_W     = 18,
  parameter int                DUR_W        = 8,
  parameter int                GAP_TICKS    = 2,
  parameter logic [NUM_EV-1:0] SUSTAIN_MASK = 4'b1000,
  parameter bit                PREEMPT      = 1'b1,
  localparam int               EW           = (NUM_EV > 1) ? $clog2(NUM_EV) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick_en,
  input  logic [NUM_EV-1:0]          ev_req,
  input  logic [NUM_EV*PERIOD_W-1:0] half_period,
  input  logic [NUM_EV*DUR_W-1:0]    duration,
  output logic                       audio,
  output logic                       gain,
  output logic                       notshutdown,
  output logic [EW-1:0]              active_ev,
  output logic                       done
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_t              state, state_nx;
  logic [NUM_EV-1:0]   pend, pend_nx, clr_mask, lower_mask;
  logic [EW-1:0]       sel, sel_nx, pick;
  logic [DUR_W-1:0]    dur_cnt, dur_nx, pick_dur;
  logic [PERIOD_W-1:0] pick_per;
  logic [GW-1:0]       gap_cnt, gap_nx;
  logic                done_nx, tone_load, pick_skip, cur_sus, natural_end;

  assign gain = GAIN_6DB;

  // Lowest pending index wins; lower_mask marks events that outrank the one playing.
  always_comb begin
    pick = '0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (pend[i]) pick = EW'(i);
    end
    lower_mask = '0;
    for (int i = 0; i < NUM_EV; i++) begin
      lower_mask[i] = (i < int'(sel));
    end
    pick_per  = half_period[int'(pick)*PERIOD_W +: PERIOD_W];
    pick_dur  = duration[int'(pick)*DUR_W +: DUR_W];
    pick_skip = (pick_per == '0) || ((pick_dur == '0) && !SUSTAIN_MASK[pick]);
    cur_sus   = SUSTAIN_MASK[sel];
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    dur_nx      = dur_cnt;
    gap_nx      = gap_cnt;
    done_nx     = 1'b0;
    tone_load   = 1'b0;
    clr_mask    = '0;
    natural_end = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          clr_mask[pick] = 1'b1;
          sel_nx         = pick;
          dur_nx         = pick_dur;
          if (pick_skip) begin
            done_nx  = 1'b1;
            state_nx = GAP;
            gap_nx   = '0;
          end else begin
            tone_load = 1'b1;
            state_nx  = PLAY;
          end
        end
      end
      PLAY: begin
        natural_end = cur_sus ? !ev_req[sel] : (tick_en && (dur_cnt == DUR_W'(1)));
        if (natural_end) begin
          done_nx  = 1'b1;
          state_nx = GAP;
          gap_nx   = '0;
        end else begin
          if (!cur_sus && tick_en) dur_nx = dur_cnt - 1'b1;
          // A preempted event is dropped, not requeued; the new one restarts the tone.
          if (PREEMPT && |(pend & lower_mask)) begin
            clr_mask[pick] = 1'b1;
            sel_nx         = pick;
            dur_nx         = pick_dur;
            if (pick_skip) begin
              done_nx  = 1'b1;
              state_nx = GAP;
              gap_nx   = '0;
            end else begin
              tone_load = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (GAP_TICKS == 0) begin
          state_nx = IDLE;
        end else if (tick_en) begin
          if (int'(gap_cnt) == GAP_TICKS - 1) begin
            state_nx = IDLE;
            gap_nx   = '0;
          end else begin
            gap_nx = gap_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    pend_nx = (pend & ~clr_mask & ~(SUSTAIN_MASK & ~ev_req)) | ev_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      sel         <= '0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      done        <= 1'b0;
      notshutdown <= 1'b0;
      active_ev   <= '0;
    end else begin
      state       <= state_nx;
      pend        <= pend_nx;
      sel         <= sel_nx;
      dur_cnt     <= dur_nx;
      gap_cnt     <= gap_nx;
      done        <= done_nx;
      notshutdown <= (state_nx == PLAY);
      active_ev   <= (state_nx == PLAY) ? sel_nx : '0;
    end
  end

  tone_gen #(.PERIOD_W(PERIOD_W)) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tone_load),
    .clear  (state_nx != PLAY),
    .period (pick_per),
    .audio  (audio)
  );

endmodule

// File: doc/sound_event_sequencer.md
Name: sound_event_sequencer

Overview:
- Parametrised successor to the game's sound controller. Accepts NUM_EV independent sound-event requests (push left, push right, speed round, win, ...) and latches them as pending.
- Plays one event at a time using fixed priority, with optional preemption, sustained (level-held) events, per-event programmable note period and duration, and a silent gap between events.
- Drives the audio amplifier pins: audio, gain, notshutdown.

Parameters:
- NUM_EV, 4, number of event channels; index 0 has the highest priority.
- PERIOD_W, 18, width of each note half-period, in clk cycles.
- DUR_W, 8, width of each event duration, in tick_en pulses.
- GAP_TICKS, 2, silent tick_en pulses inserted after every event ends or is skipped.
- SUSTAIN_MASK, 4'b1000, per-event: 1 means the event plays while ev_req stays high and its duration is ignored.
- PREEMPT, 1, 1 means a higher-priority pending event aborts the event currently playing.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_en  in  1  single-cycle slow-time enable (the game's slow enable).
- ev_req  in  NUM_EV  event requests; pulses for normal events, levels for sustained events.
- half_period  in  NUM_EV*PERIOD_W  note half-period per event; event i occupies bits [i*PERIOD_W +: PERIOD_W].
- duration  in  NUM_EV*DUR_W  duration in ticks per event, same packing.
- audio  out  1  square-wave output to the amplifier.
- gain  out  1  tied to 1 (6 dB).
- notshutdown  out  1  amplifier enable; 1 only in PLAY.
- active_ev  out  $clog2(NUM_EV)  index of the event playing; 0 when not playing.
- done  out  1  one-cycle pulse when an event completes or is skipped.

Behaviour:
- Reset (rst_n=0, asynchronous): the following are all 0 — pend, state, audio, notshutdown, active_ev, done, and all counters. Reset mid-note silences the output immediately with no done pulse.
- Pending latch:
  - pend[i] is set in any cycle where ev_req[i]=1.
  - pend[i] is cleared on the cycle event i is selected.
  - For sustained events, pend[i] is also cleared whenever ev_req[i]=0.
  - A request for the event currently playing re-sets pend, so the event replays after its gap.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If pend is nonzero, select the lowest set index s and latch half_period[s] and duration[s].
  - If the latched period is 0, or the duration is 0 on a non-sustained event, the event is skipped: done pulses and the FSM goes to GAP.
  - Otherwise go to PLAY with the phase counter at 0 and audio at 0.
  - Latency: ev_req high in cycle N → pend in N+1 → PLAY in N+2. The first audio toggle occurs half_period cycles after PLAY is entered.
- PLAY:
  - notshutdown=1; active_ev=s.
  - The phase counter increments every clk. When it reaches half_period-1 it wraps to 0 and audio toggles.
  - Non-sustained event: the duration counter decrements on each tick_en. The tick that would take it to 0 ends the event: done pulses and the FSM goes to GAP.
  - Sustained event: the event ends on the first cycle ev_req[s]=0; done pulses and the FSM goes to GAP.
  - Preemption (PREEMPT=1): if any pend[j] with j<s is set, the current event is aborted (no done, not requeued). The FSM stays in PLAY, reselects j, reloads its period and duration, and resets phase and audio to 0.
  - When PREEMPT=0, new requests only queue.
  - If a natural end and a preemption occur in the same cycle, the natural end wins: done pulses and the FSM goes to GAP.
- GAP:
  - audio=0, notshutdown=0, active_ev=0.
  - Count GAP_TICKS tick_en pulses, then go to IDLE.
  - If GAP_TICKS=0, go to IDLE on the next cycle.
- Arithmetic:
  - Counters are unsigned at full parameter width with no saturation; the configured period and duration are sampled only at selection.
  - A half_period of 1 toggles audio every cycle.
  - Changing half_period or duration inputs mid-event has no effect.
- Outputs are registered; done is high for exactly 1 cycle.

Decomposition:
- Shared package snd_pkg holds:
  - the state enum (IDLE, PLAY, GAP);
  - default note half-period constants (NOTE_A, NOTE_G, NOTE_C at a 50 MHz clk);
  - the GAIN_6DB constant.
- Natural sub-module: tone_gen (phase counter plus audio toggle, with load/clear inputs), instantiated once.
- Priority select stays inline.

Test Plan:
- Single event: ev_req[1] pulse, half_period=5, duration=3.
  - audio toggles every 5 cycles.
  - done pulses on the 3rd tick_en; notshutdown falls on that same edge.
  - After 2 gap ticks the FSM returns to IDLE.
- Simultaneous requests: ev_req=4'b0110 in one cycle → event 1 plays first, then event 2 after the gap; 2 done pulses.
- Preemption (PREEMPT=1): event 2 playing, ev_req[0] pulse.
  - PLAY restarts with active_ev=0 and audio=0.
  - No done pulse for event 2; event 2 is not replayed.
  - Repeat with PREEMPT=0: event 0 plays after event 2 completes.
- Sustained event 3: hold ev_req[3] for 40 ticks with duration=1 → plays all 40 ticks; release → done and GAP next cycle.
- Skip: half_period[0]=0, request event 0 → done pulse, notshutdown stays 0, FSM goes to GAP.
- Reset: assert rst_n=0 mid-PLAY → audio, notshutdown and pend are 0 asynchronously; after release the FSM is in IDLE and no event plays.
